// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of DEPTH x WIDTH entries with push, pop, clear, count and head.
// Latency: a push is visible at head / count one cycle later.
// Backpressure: none internally; the owner guarantees no push when full and no pop when empty.
//   ports: clk, rst (async active-low), push/push_data, pop, clear (drops all entries),
//          count (occupancy), head (oldest entry, undefined when count == 0)
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointer wrap handles non-power-of-two depths.
  function automatic logic [AW-1:0] ptr_incr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_incr(wr_ptr);
      if (pop)  rd_ptr <= ptr_incr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests, queues {pc, instr} responses for decode, handles redirects.
// Latency: memory latency + 1 cycle from request acceptance to validF.
// Backpressure: credit limit DEPTH on requests + queued instructions; id_write = 0 holds the queue head.
//   ports: clk, rst (async active-low), imem_req_* (valid/ready request), imem_rsp_* (in-order beats),
//          id_write (decode consumes), redirect/redirect_pc (flush + new target), validF/pcF/instrF (queue head)
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        validF,
  output logic [31:0] pcF,
  output logic [31:0] instrF
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t  state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [CW-1:0] out_cnt, out_cnt_next;
  logic [CW-1:0] drop_cnt, drop_cnt_next;
  logic [CW-1:0] q_cnt;
  logic [CW-1:0] pcq_cnt;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_keep;
  logic          q_pop;
  logic [31:0]   inflight_pc;
  logic [63:0]   q_head;
  logic          unused_pcq;

  // Requests are gated by rst so nothing is offered while reset is held.
  assign credit_used    = {1'b0, out_cnt} + {1'b0, q_cnt};
  assign imem_req_valid = rst && (state == FETCH) && !redirect &&
                          (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Beats during a redirect or while stale requests drain never reach the queue.
  assign rsp_keep = imem_rsp_valid && !redirect && (drop_cnt == '0);

  assign validF = (q_cnt != '0);
  assign q_pop  = validF && id_write && !redirect;
  assign pcF    = validF ? q_head[63:32] : 32'h0;
  assign instrF = validF ? q_head[31:0]  : NOP_INSTR;

  always_comb begin
    out_cnt_next  = out_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_next = drop_cnt;
    fetch_pc_next = fetch_pc;
    state_next    = state;
    if (req_fire) fetch_pc_next = fetch_pc + 32'd4;
    if (redirect) begin
      // Everything still unanswered after this cycle belongs to the old path.
      fetch_pc_next = redirect_pc & ~32'h3;
      drop_cnt_next = out_cnt_next;
      state_next    = (out_cnt_next != '0) ? DRAIN : FETCH;
    end else begin
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt_next = drop_cnt - CW'(1);
      if ((state == DRAIN) && (drop_cnt_next == '0)) state_next = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      out_cnt  <= out_cnt_next;
      drop_cnt <= drop_cnt_next;
    end
  end

  // Instruction queue seen by decode.
  fetch_queue #(.DEPTH(DEPTH), .WIDTH(64)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data ({inflight_pc, imem_rsp_data}),
    .pop       (q_pop),
    .clear     (redirect),
    .count     (q_cnt),
    .head      (q_head)
  );

  // PCs of live requests; cleared on redirect because drained beats never pop it.
  fetch_queue #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .clear     (redirect),
    .count     (pcq_cnt),
    .head      (inflight_pc)
  );

  assign unused_pcq = ^pcq_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import pipeline_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        validF;
  logic [31:0] pcF;
  logic [31:0] instrF;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_write       (id_write),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .validF         (validF),
    .pcF            (pcF),
    .instrF         (instrF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          lat   = 1;
  logic [31:0] mem_addr [$];
  int          mem_due  [$];
  logic [31:0] acc_log  [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive the memory response, sample the request, clock, return at negedge.
  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    logic        rsp_taken;
    if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {16'hC0DE, mem_addr[0][15:0]};
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    acc       = imem_req_valid && imem_req_ready;
    acc_addr  = imem_req_addr;
    rsp_taken = imem_rsp_valid;
    @(posedge clk);
    if (rsp_taken) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (acc) begin
      mem_addr.push_back(acc_addr);
      mem_due.push_back(cyc + lat);
      acc_log.push_back(acc_addr);
    end
    cyc++;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] exp_addr;
    logic [31:0] pc_seq [4];
    pc_seq = '{32'h8, 32'hC, 32'h10, 32'h14};

    rst = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    id_write = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    #3;
    chk("rst_validF", {31'b0, validF}, 32'h0);
    chk("rst_pcF", pcF, 32'h0);
    chk("rst_instrF", instrF, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; cyc = 0;
    #1;
    chk("rel_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("rel_req_addr", imem_req_addr, 32'h0);

    // Streaming with 1-cycle memory: first instruction two cycles after the first request.
    tick();
    chk("fill_validF", {31'b0, validF}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stream_pcF", pcF, 32'(k * 4));
      chk("stream_instr", instrF, 32'hC0DE_0000 + 32'(k * 4));
    end
    chk("req0", acc_log[0], 32'h0);
    chk("req1", acc_log[1], 32'h4);
    chk("req2", acc_log[2], 32'h8);

    // Decode stall for 5 cycles: queue fills to DEPTH, requests stop, head holds.
    id_write = 1'b0;
    repeat (5) tick();
    chk("stall_q_cnt", 32'(dut.q_cnt), 32'd3);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("stall_pcF", pcF, 32'h8);
    id_write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("release_pcF", pcF, pc_seq[k]);
      tick();
    end

    // Quiesce, then redirect with two requests outstanding on a 3-cycle memory.
    imem_req_ready = 1'b0;
    repeat (3) tick();
    chk("quiet_addr", imem_req_addr, 32'h20);
    chk("quiet_validF", {31'b0, validF}, 32'h0);
    lat = 3; imem_req_ready = 1'b1;
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    chk("redir_no_req", {31'b0, imem_req_valid}, 32'h0);
    tick();
    redirect = 1'b0;
    chk("drain_state", 32'(dut.state), 32'(DRAIN));
    chk("drain_no_req", {31'b0, imem_req_valid}, 32'h0);
    tick();
    tick();
    chk("post_drain_req", {31'b0, imem_req_valid}, 32'h1);
    chk("post_drain_addr", imem_req_addr, 32'h100);
    n = 0;
    while (!validF && n < 12) begin tick(); n++; end
    chk("redir_wait", 32'(n), 32'd4);
    chk("redir_pcF", pcF, 32'h100);
    chk("redir_instr", instrF, 32'hC0DE_0100);

    // Redirect coinciding with a response and a would-be pop.
    redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    chk("redir2_no_req", {31'b0, imem_req_valid}, 32'h0);
    tick();
    redirect = 1'b0;
    chk("redir2_validF", {31'b0, validF}, 32'h0);
    chk("redir2_pcF", pcF, 32'h0);
    chk("redir2_instrF", instrF, 32'h0);
    chk("redir2_state", 32'(dut.state), 32'(DRAIN));
    n = 0;
    while (!validF && n < 12) begin tick(); n++; end
    chk("redir2_wait", 32'(n), 32'd5);
    chk("redir2_pcF_new", pcF, 32'h200);
    chk("redir2_instr_new", instrF, 32'hC0DE_0200);

    // Ready toggling: address holds while stalled, accepted sequence has no gaps.
    imem_req_ready = 1'b0;
    repeat (6) tick();
    chk("toggle_idle_valid", {31'b0, validF}, 32'h0);
    lat = 1;
    exp_addr = 32'h20C;
    for (int i = 0; i < 8; i++) begin
      imem_req_ready = (i % 2 == 0);
      #1;
      chk("toggle_req_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("toggle_addr", imem_req_addr, exp_addr);
      tick();
      if (i % 2 == 0) exp_addr = exp_addr + 32'd4;
    end

    // Asynchronous reset with two requests in flight.
    id_write = 1'b0; lat = 3; imem_req_ready = 1'b1;
    tick();
    tick();
    chk("pre_rst_validF", {31'b0, validF}, 32'h1);
    chk("pre_rst_pcF", pcF, 32'h218);
    chk("pre_rst_no_req", {31'b0, imem_req_valid}, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_validF", {31'b0, validF}, 32'h0);
    chk("arst_pcF", pcF, 32'h0);
    chk("arst_instrF", instrF, 32'h0);
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    mem_addr.delete();
    mem_due.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; cyc = 0; lat = 1; id_write = 1'b1;
    #1;
    chk("rerel_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("rerel_req_addr", imem_req_addr, 32'h0);
    tick();
    tick();
    chk("rerel_validF", {31'b0, validF}, 32'h1);
    chk("rerel_pcF", pcF, 32'h0);
    chk("rerel_instrF", instrF, 32'hC0DE_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: fetch-queue entries, and also the maximum number of requests plus queued instructions in flight (credit limit); legal values are 2 to 8.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  out  1  instruction-memory request.
REQ-006 imem_req_addr  out  32  word-aligned fetch address.
REQ-007 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-008 imem_rsp_valid  in  1  response beat; responses return in request order, with latency of 1 or more cycles.
REQ-009 imem_rsp_data  in  32  instruction word.
REQ-010 id_write  in  1  IF/ID write enable from hazard_unit (1 = decode consumes, 0 = stall).
REQ-011 redirect  in  1  branch/jump taken; asserted in the same cycle as the IF/ID flush.
REQ-012 redirect_pc  in  32  new fetch target.
REQ-013 validF  out  1  pcF/instrF hold a real instruction.
REQ-014 pcF  out  32  PC of the queue head.
REQ-015 instrF  out  32  instruction at the queue head.

Function
REQ-016 A request is accepted when imem_req_valid and imem_req_ready are both high; on acceptance, fetch_pc advances by 4 (modulo 2^32) and its PC is pushed into an in-flight PC FIFO.
REQ-017 imem_req_valid = (state == FETCH) && !redirect && (out_cnt + q_cnt < DEPTH); imem_req_addr = fetch_pc.
REQ-018 A non-dropped response pushes {in-flight PC, imem_rsp_data} into the queue in the same cycle; the queue can never overflow because of the credit rule in REQ-017.
REQ-019 validF = (q_cnt != 0); while the queue is empty, pcF = 0 and instrF = 0 (NOP).
REQ-020 The queue head pops when validF && id_write && !redirect; a push and a pop in the same cycle leave q_cnt unchanged.
REQ-021 Fall-through: a response arriving into an empty queue is visible on validF in the next cycle; minimum fetch-to-IF latency is therefore memory latency + 1.
REQ-022 On redirect:
  - queue cleared;
  - fetch_pc <= redirect_pc;
  - drop_cnt <= every request still unanswered after this cycle;
  - no request is issued in this cycle;
  - state moves to DRAIN if drop_cnt_next != 0, else to FETCH.
REQ-023 While drop_cnt != 0, each response is discarded (not queued) and decrements drop_cnt and out_cnt.
REQ-024 FSM states and transitions:
  - FETCH -> DRAIN on redirect with stale in-flight requests;
  - DRAIN -> FETCH in the cycle drop_cnt reaches 0;
  - DRAIN -> DRAIN on a further redirect, which only updates fetch_pc.
REQ-025 A response in the same cycle as redirect is always discarded.
REQ-026 redirect_pc[1:0] is ignored (forced to 00).
REQ-027 The counters out_cnt, q_cnt and drop_cnt are $clog2(DEPTH+1) bits wide; underflow or overflow is a design error.

Reset
REQ-028 While rst = 0 (asynchronous assert):
  - fetch_pc = RESET_PC;
  - state = FETCH;
  - all counters = 0;
  - queue empty;
  - validF = 0, pcF = 0, instrF = 0, imem_req_valid = 0.
REQ-029 Reset deassertion is synchronous to clk; the first request (addr RESET_PC) is issued in the first cycle after release.
REQ-030 Reset with requests in flight discards their state; responses arriving after reset for those requests are not the memory's obligation, and the bench shall not generate them.

Structure
REQ-031 Shared package pipeline_pkg holds fetch_state_t (FETCH, DRAIN), NOP_INSTR = 32'h0, and the default RESET_PC.
REQ-032 One sub-module, fetch_queue: a synchronous FIFO of DEPTH x 64 bits {pc, instr} with push, pop, clear, count, and head outputs; the in-flight PC FIFO reuses it with a 32-bit width parameter.

Verification
REQ-033 Reset, then 1-cycle memory, id_write = 1 -> requests at 0x0, 0x4, 0x8; pcF/instrF stream 0x0, 0x4, ... with one instruction per cycle after a 2-cycle fill.
REQ-034 Hold id_write = 0 for 5 cycles -> q_cnt saturates at DEPTH; imem_req_valid = 0; pcF stays constant; no instruction is lost on release.
REQ-035 Redirect to 0x100 with 2 requests outstanding (3-cycle memory) -> both responses discarded; state passes through DRAIN; next validF shows pcF = 0x100.
REQ-036 Redirect in the same cycle as a response and a pop -> the response is dropped, the queue is empty next cycle, and no double pop occurs.
REQ-037 imem_req_ready toggling 1/0 -> imem_req_addr stays stable while stalled and the address sequence has no gaps.
REQ-038 rst asserted mid-stream with 2 in flight -> outputs are 0 immediately (asynchronously); after release the first request is RESET_PC.
